// File: rtl/mux_sync_pkg.sv
// Shared types and constants for the mux-synchronizer handshake.
// Holds the source FSM state type and the synchronizer depth floor.
package mux_sync_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/mux_sync_hs_sync_bit.sv
// sync_bit: STAGES-deep single-bit synchronizer.
// Ports: clk, rstn (async low), d (foreign domain), q (clk domain).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/mux_sync_hs.sv
// mux_sync_hs: word CDC via stable hold register + req/ack toggles.
// clk_a/arstn: a_data,a_valid,a_ready; clk_b/brstn: b_data,b_valid.
module mux_sync_hs
  import mux_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_a,
  input  logic             arstn,
  input  logic             clk_b,
  input  logic             brstn,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || WIDTH < 1) begin : g_bad
    $error("mux_sync_hs: bad WIDTH/SYNC_STAGES");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] hold;
  logic             req;
  logic             ack_s;
  logic             accept;

  logic             req_s;
  logic             req_d;
  logic             req_chg;
  logic             ack;

  assign a_ready = (state == IDLE);
  assign accept  = a_valid & a_ready;

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
      hold  <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        hold <= a_data;
        req  <= ~req;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (a_valid) state_nx = WAIT_ACK;
      end
      (state == WAIT_ACK): begin
        // ack catches up with req: the word has landed in clk_b
        if (ack_s == req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk  (clk_b),
    .rstn (brstn),
    .d    (req),
    .q    (req_s)
  );

  assign req_chg = req_s ^ req_d;

  always_ff @(posedge clk_b or negedge brstn) begin
    if (!brstn) begin
      req_d   <= 1'b0;
      b_valid <= 1'b0;
      b_data  <= '0;
      ack     <= 1'b0;
    end else begin
      req_d   <= req_s;
      b_valid <= req_chg;
      if (req_chg) begin
        // hold is frozen while req is in flight
        b_data <= hold;
        ack    <= req_s;
      end
    end
  end

  sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk_a),
    .rstn (arstn),
    .d    (ack),
    .q    (ack_s)
  );

endmodule

// File: tb/tb_mux_sync_hs.sv
// Bench for mux_sync_hs: aligned latency/back-pressure/reset,
// plus two async random streams checked against a word queue.
module tb_mux_sync_hs;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // aligned instance: one clock drives both domains
  logic       clk0 = 0;
  logic       ar0 = 0, br0 = 0;
  logic [7:0] ad0 = 0;
  logic       av0 = 0;
  logic       rdy0;
  logic [7:0] bd0;
  logic       bv0;

  // async stream: clk_a 10 ns, clk_b 37 ns
  logic       ca1 = 0, cb1 = 0;
  logic       ar1 = 0, br1 = 0;
  logic [7:0] ad1 = 0;
  logic       av1 = 0;
  logic       rdy1;
  logic [7:0] bd1;
  logic       bv1;

  // fast dest: clk_a 37 ns, clk_b 10 ns, 16 bit, 3 stages
  logic        ca2 = 0, cb2 = 0;
  logic        ar2 = 0, br2 = 0;
  logic [15:0] ad2 = 0;
  logic        av2 = 0;
  logic        rdy2;
  logic [15:0] bd2;
  logic        bv2;

  always #5 clk0 = ~clk0;
  always #5 ca1 = ~ca1;
  always begin #18 cb1 = 1; #19 cb1 = 0; end
  always begin #18 ca2 = 1; #19 ca2 = 0; end
  always #5 cb2 = ~cb2;

  mux_sync_hs u0 (
    .clk_a(clk0), .arstn(ar0), .clk_b(clk0), .brstn(br0),
    .a_data(ad0), .a_valid(av0), .a_ready(rdy0),
    .b_data(bd0), .b_valid(bv0)
  );

  mux_sync_hs #(.WIDTH(8), .SYNC_STAGES(2)) u1 (
    .clk_a(ca1), .arstn(ar1), .clk_b(cb1), .brstn(br1),
    .a_data(ad1), .a_valid(av1), .a_ready(rdy1),
    .b_data(bd1), .b_valid(bv1)
  );

  mux_sync_hs #(.WIDTH(16), .SYNC_STAGES(3)) u2 (
    .clk_a(ca2), .arstn(ar2), .clk_b(cb2), .brstn(br2),
    .a_data(ad2), .a_valid(av2), .a_ready(rdy2),
    .b_data(bd2), .b_valid(bv2)
  );

  // ---------------- aligned instance ----------------
  localparam int N0 = 2;
  logic [7:0] exp_bd0 = 0;

  task automatic tick0();
    @(posedge clk0);
    #1;
  endtask

  // model: accept when ready & valid; ready returns 2N+2
  // edges after accept; delivery pulse N+1 edges after accept
  task automatic sched0(input bit keep, input int cycles,
                        input logic [7:0] first, input string tg);
    logic [7:0] d [0:31];
    bit         acc [0:31];
    bit         rdy;
    int         lastacc;
    logic [7:0] la;
    bit         ev;
    rdy = 1;
    lastacc = -100;
    la = exp_bd0;
    for (int k = 0; k < 32; k++) begin
      d[k] = 8'($urandom);
      acc[k] = 0;
    end
    d[0] = first;
    for (int k = 0; k < cycles; k++) begin
      av0 = (k == 0) || keep;
      ad0 = d[k];
      tick0();
      if (rdy && av0) begin
        acc[k] = 1;
        lastacc = k;
        la = d[k];
      end
      rdy = (k - lastacc) >= 2 * N0 + 2;
      ev = (k >= N0 + 1) && acc[k-N0-1];
      if (ev) exp_bd0 = d[k-N0-1];
      chk({tg, "_rdy"}, rdy0, rdy);
      chk({tg, "_bv"}, bv0, ev);
      chk({tg, "_bd"}, bd0, exp_bd0);
    end
    av0 = 0;
    repeat (2 * N0 + 4) @(posedge clk0);
    #1;
    exp_bd0 = la;
    chk({tg, "_q_bd"}, bd0, exp_bd0);
    chk({tg, "_q_rdy"}, rdy0, 1);
  endtask

  task automatic run_aligned();
    av0 = 1;
    ad0 = 8'h77;
    repeat (3) tick0();
    chk("rst_rdy", rdy0, 1);
    chk("rst_bv", bv0, 0);
    chk("rst_bd", bd0, 0);
    av0 = 0;
    ar0 = 1;
    br0 = 1;
    for (int i = 0; i < 3; i++) begin
      tick0();
      chk("rel_rdy", rdy0, 1);
      chk("rel_bv", bv0, 0);
      chk("rel_bd", bd0, 0);
    end
    sched0(0, 10, 8'hA5, "one");
    sched0(1, 17, 8'h3C, "bp");
    sched0(0, 8, 8'hC3, "two");
    // reset in the middle of WAIT_ACK
    av0 = 1;
    ad0 = 8'h5A;
    tick0();
    av0 = 0;
    tick0();
    chk("mid_wait", rdy0, 0);
    ar0 = 0;
    br0 = 0;
    #1;
    chk("mid_rdy_in", rdy0, 1);
    repeat (3) tick0();
    chk("mid_bd_in", bd0, 0);
    ar0 = 1;
    br0 = 1;
    exp_bd0 = 0;
    for (int i = 0; i < 10; i++) begin
      tick0();
      chk("mid_rdy", rdy0, 1);
      chk("mid_bv", bv0, 0);
      chk("mid_bd", bd0, 0);
    end
    sched0(0, 8, 8'h96, "post");
  endtask

  // ---------------- stream 1 ----------------
  logic [7:0] q1 [$];
  bit         mon1 = 0;
  bit         pv1 = 0;
  logic [7:0] last1 = 0;
  int         np1 = 0;

  always @(posedge cb1) begin
    #1;
    if (mon1) begin
      if (bv1) begin
        np1++;
        chk("s1_wide", pv1, 0);
        if (q1.size() == 0) begin
          chk("s1_extra", 1, 0);
        end else begin
          last1 = q1.pop_front();
          chk("s1_data", bd1, last1);
        end
      end else begin
        chk("s1_hold", bd1, last1);
      end
      pv1 = bv1;
    end
  end

  task automatic run_s1();
    bit got;
    bit r;
    logic [7:0] w;
    repeat (3) @(posedge cb1);
    ar1 = 1;
    br1 = 1;
    @(posedge ca1);
    #1;
    mon1 = 1;
    for (int i = 0; i < 100; i++) begin
      w = 8'($urandom);
      q1.push_back(w);
      ad1 = w;
      av1 = 1;
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        r = rdy1;
        @(posedge ca1);
        #1;
        got = r;
      end
      if (!got) chk("s1_acc_to", 0, 1);
    end
    av1 = 0;
    for (int t = 0; t < 400 && q1.size() != 0; t++)
      @(posedge cb1);
    repeat (4) @(posedge cb1);
    #2;
    chk("s1_left", q1.size(), 0);
    chk("s1_cnt", np1, 100);
    mon1 = 0;
  endtask

  // ---------------- stream 2 ----------------
  logic [15:0] q2 [$];
  bit          mon2 = 0;
  bit          pv2 = 0;
  logic [15:0] last2 = 0;
  int          np2 = 0;

  always @(posedge cb2) begin
    #1;
    if (mon2) begin
      if (bv2) begin
        np2++;
        chk("s2_wide", pv2, 0);
        if (q2.size() == 0) begin
          chk("s2_extra", 1, 0);
        end else begin
          last2 = q2.pop_front();
          chk("s2_data", bd2, last2);
        end
      end else begin
        chk("s2_hold", bd2, last2);
      end
      pv2 = bv2;
    end
  end

  task automatic run_s2();
    bit got;
    bit r;
    logic [15:0] w;
    repeat (3) @(posedge ca2);
    ar2 = 1;
    br2 = 1;
    @(posedge ca2);
    #1;
    mon2 = 1;
    for (int i = 0; i < 100; i++) begin
      w = 16'($urandom);
      q2.push_back(w);
      ad2 = w;
      av2 = 1;
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        r = rdy2;
        @(posedge ca2);
        #1;
        got = r;
      end
      if (!got) chk("s2_acc_to", 0, 1);
    end
    av2 = 0;
    for (int t = 0; t < 400 && q2.size() != 0; t++)
      @(posedge cb2);
    repeat (4) @(posedge cb2);
    #2;
    chk("s2_left", q2.size(), 0);
    chk("s2_cnt", np2, 100);
    mon2 = 0;
  endtask

  initial begin
    fork
      run_aligned();
      run_s1();
      run_s2();
    join
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
